// File: rtl/bcp_decision_unit.sv
// Picks the lowest-index free variable, clears its free bit and writes the chosen polarity into the value row.
// Latency: done 7 cycles after start, or 3 when nothing is free. A start while busy is dropped, not queued.
module bcp_decision_unit #(
   parameter int VAR_NUM     = 8,
   parameter int VAR_NUM_LOG = 3,
   parameter int FREE_ROW    = 0,
   parameter int VALUE_ROW   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dec_start,
   input  logic                   dec_polarity,
   output logic                   dec_busy,
   output logic                   dec_done,
   output logic [VAR_NUM_LOG-1:0] dec_var,
   output logic                   dec_all_assigned,
   output logic                   vst_en,
   output logic                   vst_write,
   output logic                   vst_bcp_write,
   output logic [2:0]             vst_address,
   output logic [VAR_NUM_LOG-1:0] rewrite_free_bit,
   output logic [VAR_NUM-1:0]     vst_in,
   input  logic [VAR_NUM-1:0]     vst_out
);

   typedef enum logic [2:0] {
      IDLE, RD_FREE, CAP_FREE, CLR_FREE, RD_VAL, CAP_VAL, WR_VAL, DONE
   } state_t;

   state_t                   state;
   logic                     polarity_q;
   logic [VAR_NUM-1:0]       val_q;
   logic [VAR_NUM_LOG-1:0]   low_idx;
   logic [VAR_NUM-1:0]       merged_val;

   // Descending scan so the last hit, i.e. the lowest set bit, wins.
   always_comb begin
      low_idx = '0;
      for (int i = VAR_NUM - 1; i >= 0; i--) begin
         if (vst_out[i]) low_idx = VAR_NUM_LOG'(i);
      end
   end

   always_comb begin
      merged_val          = val_q;
      merged_val[dec_var] = polarity_q;
   end

   // Data fields follow the state register so they are zero outside their write cycle.
   assign rewrite_free_bit = (state == CLR_FREE) ? dec_var    : '0;
   assign vst_in           = (state == WR_VAL)   ? merged_val : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         polarity_q       <= 1'b0;
         val_q            <= '0;
         dec_busy         <= 1'b0;
         dec_done         <= 1'b0;
         dec_var          <= '0;
         dec_all_assigned <= 1'b0;
         vst_en           <= 1'b0;
         vst_write        <= 1'b0;
         vst_bcp_write    <= 1'b0;
         vst_address      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dec_start) begin
                  polarity_q       <= dec_polarity;
                  dec_var          <= '0;
                  dec_all_assigned <= 1'b0;
                  dec_busy         <= 1'b1;
                  vst_en           <= 1'b1;
                  vst_address      <= 3'(FREE_ROW);
                  state            <= RD_FREE;
               end
            end
            RD_FREE: begin
               vst_en      <= 1'b0;
               vst_address <= '0;
               state       <= CAP_FREE;
            end
            CAP_FREE: begin
               if (vst_out == '0) begin
                  dec_all_assigned <= 1'b1;
                  dec_done         <= 1'b1;
                  state            <= DONE;
               end else begin
                  dec_var     <= low_idx;
                  vst_en      <= 1'b1;
                  vst_write   <= 1'b1;
                  vst_address <= 3'(FREE_ROW);
                  state       <= CLR_FREE;
               end
            end
            CLR_FREE: begin
               vst_write   <= 1'b0;
               vst_address <= 3'(VALUE_ROW);
               state       <= RD_VAL;
            end
            RD_VAL: begin
               vst_en      <= 1'b0;
               vst_address <= '0;
               state       <= CAP_VAL;
            end
            CAP_VAL: begin
               val_q         <= vst_out;
               vst_en        <= 1'b1;
               vst_bcp_write <= 1'b1;
               vst_address   <= 3'(VALUE_ROW);
               state         <= WR_VAL;
            end
            WR_VAL: begin
               vst_en        <= 1'b0;
               vst_bcp_write <= 1'b0;
               vst_address   <= '0;
               dec_done      <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               dec_done <= 1'b0;
               dec_busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcp_decision_unit.sv
// Directed bench for bcp_decision_unit with a behavioural model of the variable state table.
module tb_bcp_decision_unit;

   logic       clk;
   logic       rst;
   logic       dec_start;
   logic       dec_polarity;
   logic       dec_busy;
   logic       dec_done;
   logic [2:0] dec_var;
   logic       dec_all_assigned;
   logic       vst_en;
   logic       vst_write;
   logic       vst_bcp_write;
   logic [2:0] vst_address;
   logic [2:0] rewrite_free_bit;
   logic [7:0] vst_in;
   logic [7:0] vst_out;

   logic [7:0] tbl_free;
   logic [7:0] tbl_val;
   int         wr_cnt;
   int         bcp_cnt;
   int         viol_cnt;
   int         n_tests;
   int         n_fail;
   int         cyc;
   int         idle_bad;

   bcp_decision_unit dut (
      .clk              (clk),
      .rst              (rst),
      .dec_start        (dec_start),
      .dec_polarity     (dec_polarity),
      .dec_busy         (dec_busy),
      .dec_done         (dec_done),
      .dec_var          (dec_var),
      .dec_all_assigned (dec_all_assigned),
      .vst_en           (vst_en),
      .vst_write        (vst_write),
      .vst_bcp_write    (vst_bcp_write),
      .vst_address      (vst_address),
      .rewrite_free_bit (rewrite_free_bit),
      .vst_in           (vst_in),
      .vst_out          (vst_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Table model: registered read, zero read data after a disabled cycle.
   always @(posedge clk) begin
      if (vst_en) begin
         if (vst_address == 3'd0) vst_out <= tbl_free;
         else if (vst_address == 3'd2) vst_out <= tbl_val;
         else vst_out <= 8'h00;
         if (vst_write) begin
            wr_cnt = wr_cnt + 1;
            if (vst_address == 3'd0) tbl_free[rewrite_free_bit] = 1'b0;
         end else if (vst_bcp_write) begin
            bcp_cnt = bcp_cnt + 1;
            if (vst_address == 3'd2) tbl_val = vst_in;
         end
      end else begin
         vst_out <= 8'h00;
      end
   end

   always @(negedge clk) begin
      if ((vst_write && vst_bcp_write) ||
          (!vst_en && vst_address != 3'd0) ||
          (!vst_write && rewrite_free_bit != 3'd0) ||
          (!vst_bcp_write && vst_in != 8'h00))
         viol_cnt = viol_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one decision; returns the cycle (after the sampling edge) in which dec_done was seen, or 0.
   task automatic run_dec(input logic pol, input logic inject, output int done_cyc);
      @(negedge clk);
      dec_polarity = pol;
      dec_start    = 1'b1;
      wr_cnt       = 0;
      bcp_cnt      = 0;
      @(posedge clk);
      #1;
      dec_start    = 1'b0;
      dec_polarity = ~pol;
      done_cyc     = 0;
      for (int k = 1; k <= 20; k++) begin
         dec_start = inject && (k == 3 || k == 7);
         if (dec_done) begin
            done_cyc = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (dec_start) begin
         @(posedge clk);
         #1;
         dec_start = 1'b0;
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; viol_cnt = 0; wr_cnt = 0; bcp_cnt = 0; idle_bad = 0;
      tbl_free = 8'hFF; tbl_val = 8'h00;
      rst = 1'b0; dec_start = 1'b0; dec_polarity = 1'b0;
      #3;
      check("rst_busy_done", {30'd0, dec_busy, dec_done}, 32'd0);
      check("rst_var_all", {28'd0, dec_var, dec_all_assigned}, 32'd0);
      check("rst_vst_ctl", {27'd0, vst_en, vst_write, vst_bcp_write, vst_address}, 32'd0);
      check("rst_vst_dat", {21'd0, rewrite_free_bit, vst_in}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if ({dec_busy, dec_done, dec_var, dec_all_assigned, vst_en, vst_write,
              vst_bcp_write, vst_address, rewrite_free_bit, vst_in} != '0)
            idle_bad = idle_bad + 1;
      end
      check("idle_quiet_cycles", idle_bad, 0);

      // First decision
      tbl_free = 8'hFF; tbl_val = 8'h00;
      run_dec(1'b1, 1'b0, cyc);
      check("first_done_cycle", cyc, 7);
      check("first_var", dec_var, 0);
      check("first_all", dec_all_assigned, 0);
      check("first_busy_in_done", dec_busy, 1);
      @(posedge clk); #1;
      check("first_free_row", tbl_free, 8'hFE);
      check("first_val_row", tbl_val, 8'h01);
      check("first_wr_cnt", wr_cnt, 1);
      check("first_bcp_cnt", bcp_cnt, 1);
      check("first_busy_after", dec_busy, 0);

      // Lowest-index selection with other value bits preserved
      tbl_free = 8'b1010_0000; tbl_val = 8'hFF;
      run_dec(1'b0, 1'b0, cyc);
      check("low_done_cycle", cyc, 7);
      check("low_var", dec_var, 5);
      repeat (3) @(posedge clk); #1;
      check("low_var_held", dec_var, 5);
      check("low_free_row", tbl_free, 8'h80);
      check("low_val_row", tbl_val, 8'hDF);

      // All assigned
      tbl_free = 8'h00; tbl_val = 8'h5A;
      run_dec(1'b1, 1'b0, cyc);
      check("all_done_cycle", cyc, 3);
      check("all_flag", dec_all_assigned, 1);
      check("all_var", dec_var, 0);
      @(posedge clk); #1;
      check("all_wr_cnt", wr_cnt, 0);
      check("all_bcp_cnt", bcp_cnt, 0);
      check("all_val_row", tbl_val, 8'h5A);

      // Busy guard, then back-to-back decisions
      tbl_free = 8'hFF; tbl_val = 8'h00;
      run_dec(1'b1, 1'b1, cyc);
      check("guard_done_cycle", cyc, 7);
      check("guard_var", dec_var, 0);
      repeat (3) @(posedge clk); #1;
      check("guard_no_restart", dec_busy, 0);
      check("guard_wr_cnt", wr_cnt, 1);
      run_dec(1'b0, 1'b0, cyc);
      check("b2b_done_cycle", cyc, 7);
      check("b2b_var", dec_var, 1);
      @(posedge clk); #1;
      check("b2b_free_row", tbl_free, 8'hFC);
      check("b2b_val_row", tbl_val, 8'h01);

      // Reset during RD_VAL
      tbl_free = 8'hF0; tbl_val = 8'h00;
      @(negedge clk);
      dec_polarity = 1'b1;
      dec_start    = 1'b1;
      @(posedge clk); #1;
      dec_start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("mid_en_before", vst_en, 1);
      rst = 1'b0;
      #1;
      check("mid_busy", dec_busy, 0);
      check("mid_en", vst_en, 0);
      check("mid_var", dec_var, 0);
      check("mid_free_kept", tbl_free, 8'hE0);
      check("mid_val_untouched", tbl_val, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      run_dec(1'b1, 1'b0, cyc);
      check("mid_next_var", dec_var, 5);
      @(posedge clk); #1;
      check("mid_next_free", tbl_free, 8'hC0);
      check("mid_next_val", tbl_val, 8'h20);

      check("protocol_violations", viol_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
